// File: rtl/vc_fifo.sv
// Multi-channel circular FIFO: VC_NUM virtual channels share one write and one read port,
// with per-channel occupancy, almost-full and overflow/underflow status.
module vc_fifo #(
   parameter int DATA_WIDTH       = 8,
   parameter int FIFO_DEPTH_WIDTH = 2,
   parameter int VC_NUM           = 2,
   parameter int VC_ID_WIDTH      = 1,
   parameter int REG_OUT          = 0,
   parameter int AF_THRESH        = 3,
   parameter int ID               = 0
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic                                     wr_en_i,
   input  logic [VC_ID_WIDTH-1:0]                   wr_vc_i,
   input  logic [DATA_WIDTH-1:0]                    data_i,
   input  logic                                     rd_en_i,
   input  logic [VC_ID_WIDTH-1:0]                   rd_vc_i,
   output logic [DATA_WIDTH-1:0]                    data_o,
   output logic [VC_NUM-1:0]                        full_o,
   output logic [VC_NUM-1:0]                        empty_o,
   output logic [VC_NUM-1:0]                        almost_full_o,
   output logic [VC_NUM*(FIFO_DEPTH_WIDTH+1)-1:0]   count_o,
   output logic [VC_NUM-1:0]                        overflow_o,
   output logic [VC_NUM-1:0]                        underflow_o
);

   localparam int PW       = FIFO_DEPTH_WIDTH + 1;
   localparam int AW       = VC_ID_WIDTH + FIFO_DEPTH_WIDTH;
   localparam int MEM_SIZE = 1 << AW;

   logic [PW-1:0]         wr_ptr_q [VC_NUM];
   logic [PW-1:0]         rd_ptr_q [VC_NUM];
   logic [PW-1:0]         cnt      [VC_NUM];
   logic [DATA_WIDTH-1:0] mem_q    [MEM_SIZE];

   logic [VC_NUM-1:0]     wr_sel, rd_sel, wr_rej, rd_rej;
   logic [VC_NUM-1:0]     overflow_q, underflow_q;
   logic [PW-1:0]         wr_ptr_sel, rd_ptr_sel;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] head;

   // Instance tag only; no hardware depends on it.
   if (ID < 0) begin : g_id_tag
   end

   // The extra wrap bit separates full (MSBs differ) from empty (pointers equal).
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      full_o        = '0;
      empty_o       = '0;
      almost_full_o = '0;
      count_o       = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         cnt[v]              = wr_ptr_q[v] - rd_ptr_q[v];
         empty_o[v]          = (wr_ptr_q[v] == rd_ptr_q[v]);
         full_o[v]           = (wr_ptr_q[v][PW-1] != rd_ptr_q[v][PW-1]) &&
                               (wr_ptr_q[v][PW-2:0] == rd_ptr_q[v][PW-2:0]);
         almost_full_o[v]    = (cnt[v] >= PW'(AF_THRESH));
         count_o[v*PW +: PW] = cnt[v];
      end
   end

   // Read side; a selector with no matching channel leaves everything idle.
   always_comb begin
      rd_sel     = '0;
      rd_rej     = '0;
      rd_ptr_sel = '0;
      rd_valid   = 1'b0;
      for (int v = 0; v < VC_NUM; v++) begin
         if (rd_vc_i == VC_ID_WIDTH'(v)) begin
            rd_ptr_sel = rd_ptr_q[v];
            rd_valid   = !empty_o[v];
            if (rd_en_i) begin
               if (empty_o[v]) rd_rej[v] = 1'b1;
               else            rd_sel[v] = 1'b1;
            end
         end
      end
   end

   // A full channel still takes a write when the same cycle pops it.
   always_comb begin
      wr_sel     = '0;
      wr_rej     = '0;
      wr_ptr_sel = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         if (wr_vc_i == VC_ID_WIDTH'(v)) begin
            wr_ptr_sel = wr_ptr_q[v];
            if (wr_en_i) begin
               if (!full_o[v] || rd_sel[v]) wr_sel[v] = 1'b1;
               else                         wr_rej[v] = 1'b1;
            end
         end
      end
   end

   assign head = mem_q[{rd_vc_i, rd_ptr_sel[FIFO_DEPTH_WIDTH-1:0]}];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int v = 0; v < VC_NUM; v++) begin
            wr_ptr_q[v] <= '0;
            rd_ptr_q[v] <= '0;
         end
         overflow_q  <= '0;
         underflow_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
         for (int v = 0; v < VC_NUM; v++) begin
            if (wr_sel[v]) wr_ptr_q[v] <= wr_ptr_q[v] + PW'(1);
            if (rd_sel[v]) rd_ptr_q[v] <= rd_ptr_q[v] + PW'(1);
         end
         overflow_q  <= wr_rej;
         underflow_q <= rd_rej;
      end
   end

   // NOTE: storage has no reset; cleared pointers make stale contents unreachable.
   always_ff @(posedge clk_i) begin
      if (|wr_sel) mem_q[{wr_vc_i, wr_ptr_sel[FIFO_DEPTH_WIDTH-1:0]}] <= data_i;
   end

   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;

   if (REG_OUT != 0) begin : g_reg_out
      logic [DATA_WIDTH-1:0] data_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni)     data_q <= '0;
         else if (|rd_sel) data_q <= head;
      end
      assign data_o = data_q;
   end else begin : g_fwft
      assign data_o = rd_valid ? head : '0;
   end

endmodule

// File: tb/tb_vc_fifo.sv
// Self-checking bench for vc_fifo: FWFT and registered-read instances driven in parallel
// and compared against per-channel queues.
module tb_vc_fifo;

   localparam int DW = 8;
   localparam int NV = 2;
   localparam int D  = 4;
   localparam int AF = 3;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          wr_en_i, rd_en_i;
   logic [0:0]    wr_vc_i, rd_vc_i;
   logic [DW-1:0] data_i;

   logic [DW-1:0] data_f, data_r;
   logic [NV-1:0] full_f, empty_f, af_f, ovf_f, unf_f;
   logic [NV-1:0] full_r, empty_r, af_r, ovf_r, unf_r;
   logic [5:0]    count_f, count_r;

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0] mq [NV][$];
   logic [DW-1:0] exp_reg;
   logic [NV-1:0] exp_ovf, exp_unf;

   always #5 clk_i = ~clk_i;

   vc_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(2), .VC_NUM(NV), .VC_ID_WIDTH(1),
             .REG_OUT(0), .AF_THRESH(AF), .ID(0)) dut_f (
      .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_vc_i(wr_vc_i), .data_i(data_i),
      .rd_en_i(rd_en_i), .rd_vc_i(rd_vc_i), .data_o(data_f), .full_o(full_f), .empty_o(empty_f),
      .almost_full_o(af_f), .count_o(count_f), .overflow_o(ovf_f), .underflow_o(unf_f));

   vc_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(2), .VC_NUM(NV), .VC_ID_WIDTH(1),
             .REG_OUT(1), .AF_THRESH(AF), .ID(1)) dut_r (
      .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_vc_i(wr_vc_i), .data_i(data_i),
      .rd_en_i(rd_en_i), .rd_vc_i(rd_vc_i), .data_o(data_r), .full_o(full_r), .empty_o(empty_r),
      .almost_full_o(af_r), .count_o(count_r), .overflow_o(ovf_r), .underflow_o(unf_r));

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic model_clear();
      for (int v = 0; v < NV; v++) mq[v].delete();
      exp_reg = '0;
      exp_ovf = '0;
      exp_unf = '0;
   endtask

   task automatic check_all();
      logic [NV-1:0] e_full, e_empty, e_af;
      logic [5:0]    e_count;
      logic [DW-1:0] e_head;
      for (int v = 0; v < NV; v++) begin
         e_full[v]          = (mq[v].size() == D);
         e_empty[v]         = (mq[v].size() == 0);
         e_af[v]            = (mq[v].size() >= AF);
         e_count[v*3 +: 3]  = 3'(mq[v].size());
      end
      e_head = (mq[rd_vc_i].size() > 0) ? mq[rd_vc_i][0] : '0;
      check("full",      32'(full_f),  32'(e_full));
      check("empty",     32'(empty_f), 32'(e_empty));
      check("almost",    32'(af_f),    32'(e_af));
      check("count",     32'(count_f), 32'(e_count));
      check("overflow",  32'(ovf_f),   32'(exp_ovf));
      check("underflow", 32'(unf_f),   32'(exp_unf));
      check("fwft_data", 32'(data_f),  32'(e_head));
      check("reg_data",  32'(data_r),  32'(exp_reg));
      check("reg_count", 32'(count_r), 32'(e_count));
      check("reg_flags", 32'({full_r, empty_r, af_r, ovf_r, unf_r}),
            32'({e_full, e_empty, e_af, exp_ovf, exp_unf}));
   endtask

   // Drive one cycle, check outputs that reflect the previous edge, then advance the model.
   task automatic cycle(input logic w, input logic [0:0] wv, input logic [DW-1:0] d,
                        input logic r, input logic [0:0] rv);
      logic rd_ok, wr_ok;
      wr_en_i = w; wr_vc_i = wv; data_i = d;
      rd_en_i = r; rd_vc_i = rv;
      #1;
      check_all();
      rd_ok   = r && (mq[rv].size() > 0);
      wr_ok   = w && ((mq[wv].size() < D) || (rd_ok && (rv == wv)));
      exp_ovf = '0;
      exp_unf = '0;
      if (w && !wr_ok) exp_ovf[wv] = 1'b1;
      if (r && !rd_ok) exp_unf[rv] = 1'b1;
      if (rd_ok) exp_reg = mq[rv].pop_front();
      if (wr_ok) mq[wv].push_back(d);
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_ni = 1'b0;
      wr_en_i = 1'b0; wr_vc_i = '0; data_i = '0;
      rd_en_i = 1'b0; rd_vc_i = '0;
      model_clear();
      #2;
      check("rst_empty", 32'(empty_f), 32'h3);
      check("rst_count", 32'(count_f), 32'h0);
      check("rst_data",  32'(data_r),  32'h0);
      @(posedge clk_i); @(posedge clk_i); #1;
      rst_ni = 1'b1;
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Fill VC0 while watching VC1 stay empty
      cycle(1'b1, 1'b0, 8'hA1, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 8'hA2, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 8'hA3, 1'b0, 1'b1);
      check("af_third", 32'(af_f), 32'h1);
      cycle(1'b1, 1'b0, 8'hA4, 1'b0, 1'b1);
      check("full_vc0", 32'(full_f), 32'h1);

      // Write into a full channel is dropped with a single overflow pulse
      cycle(1'b1, 1'b0, 8'hA5, 1'b0, 1'b1);
      check("ovf_pulse", 32'(ovf_f), 32'h1);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_clear", 32'(ovf_f), 32'h0);

      // Simultaneous read and write on a full channel
      cycle(1'b1, 1'b0, 8'hB0, 1'b1, 1'b0);
      check("rw_full_cnt", 32'(count_f[2:0]), 32'h4);
      check("fwft_head",   32'(data_f),       32'hA2);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_last", 32'(data_r), 32'hB0);

      // Fall-through vs registered read on VC1
      cycle(1'b1, 1'b1, 8'h11, 1'b0, 1'b1);
      check("fwft_peek", 32'(data_f), 32'h11);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("reg_read", 32'(data_r), 32'h11);

      // Underflow on empty VC1, and no same-cycle bypass on VC0
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("unf_pulse", 32'(unf_f), 32'h2);
      cycle(1'b1, 1'b0, 8'h5C, 1'b1, 1'b0);
      check("no_bypass", 32'(unf_f), 32'h1);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

      // Random traffic on both channels
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 99) < 60), 1'($urandom), 8'($urandom),
               1'($urandom_range(0, 99) < 50), 1'($urandom));
      end

      // Reset asserted mid-burst discards contents immediately
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 8'hC3, 1'b1, 1'b1);
      wr_en_i = 1'b1; data_i = 8'hC4; rd_en_i = 1'b0;
      #2;
      rst_ni = 1'b0;
      model_clear();
      #1;
      check("mid_rst_empty", 32'(empty_f), 32'h3);
      check("mid_rst_count", 32'(count_f), 32'h0);
      check("mid_rst_data",  32'(data_r),  32'h0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vc_fifo.md
Name: vc_fifo

Overview:
- Multi-channel buffer for NoC router input ports: VC_NUM independent circular FIFOs (virtual channels) sharing one write port and one read port.
- Generalises the single-channel FIFO in five ways:
  - every one of the 2^FIFO_DEPTH_WIDTH entries is usable;
  - per-channel occupancy and almost-full outputs;
  - selectable first-word-fall-through or registered read;
  - per-channel overflow/underflow pulses;
  - write accepted on a full channel when the same cycle reads that channel.
- Sits between link input and route/VC allocation; almost_full_o feeds upstream credit/backpressure.

Parameters:
- DATA_WIDTH, 8, flit width in bits.
- FIFO_DEPTH_WIDTH, 2, log2 of per-channel depth; depth D = 2^FIFO_DEPTH_WIDTH.
- VC_NUM, 2, number of virtual channels, >= 1.
- VC_ID_WIDTH, 1, width of channel selectors; must satisfy 2^VC_ID_WIDTH >= VC_NUM.
- REG_OUT, 0, read mode:
  - 0 = first-word-fall-through (combinational head);
  - 1 = registered read, 1-cycle latency.
- AF_THRESH, 3, almost-full threshold in entries, 1..D.
- ID, 0, instance identifier; simulation display only.

Ports:
- clk_i, input, 1, clock, rising edge.
- rst_ni, input, 1, asynchronous active-low reset.
- wr_en_i, input, 1, write request.
- wr_vc_i, input, VC_ID_WIDTH, target channel of write.
- data_i, input, DATA_WIDTH, write data.
- rd_en_i, input, 1, read request.
- rd_vc_i, input, VC_ID_WIDTH, source channel of read; also selects data_o in FWFT mode.
- data_o, output, DATA_WIDTH, read data.
- full_o, output, VC_NUM, bit v = channel v holds D entries.
- empty_o, output, VC_NUM, bit v = channel v holds 0 entries.
- almost_full_o, output, VC_NUM, bit v = count[v] >= AF_THRESH.
- count_o, output, VC_NUM*(FIFO_DEPTH_WIDTH+1), packed occupancy; channel v at bits [v*(FIFO_DEPTH_WIDTH+1) +: FIFO_DEPTH_WIDTH+1].
- overflow_o, output, VC_NUM, one-cycle pulse: rejected write last cycle.
- underflow_o, output, VC_NUM, one-cycle pulse: rejected read last cycle.

Behaviour:
- Reset (async assert, sync release):
  - all pointers and counts cleared;
  - empty_o all ones; full_o, almost_full_o, count_o all zero;
  - overflow_o, underflow_o zero;
  - data_o registered value zero.
  - Memory contents need not be cleared.
  - Reset mid-operation discards all stored flits.
- Pointers: per-channel wr/rd pointers of FIFO_DEPTH_WIDTH+1 bits; the MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - count = wr - rd modulo 2^(FIFO_DEPTH_WIDTH+1).
- Write acceptance: accepted when wr_en_i and wr_vc_i < VC_NUM and at least one of:
  - channel not full;
  - a read of the same channel is accepted in the same cycle.
  - On acceptance: store at the wr pointer, increment wr pointer.
  - Otherwise: overflow_o[wr_vc_i] pulses high the next cycle, and state is unchanged.
- Read acceptance: accepted when rd_en_i and rd_vc_i < VC_NUM and the channel is not empty.
  - On acceptance: increment rd pointer.
  - Otherwise: underflow_o[rd_vc_i] pulses high the next cycle.
- No bypass: a write to an empty channel is not readable in the same cycle; a simultaneous read underflows.
- Out-of-range selector (>= VC_NUM): write or read is ignored, no flag raised.
- Reads and writes to different channels are fully independent in the same cycle.
- REG_OUT=0:
  - data_o = head entry of channel rd_vc_i, combinational;
  - data_o = 0 when that channel is empty or rd_vc_i is out of range;
  - rd_en_i pops the shown flit.
- REG_OUT=1:
  - on an accepted read, data_o loads the head entry at the clock edge and is valid the following cycle;
  - data_o holds its value otherwise.
- Status outputs are combinational from registered pointers and update the cycle after the causing edge.
- Count wraps cleanly at every pointer rollover; the wrap bit guarantees a full channel never reads as empty.

Test Plan:
- Reset, then idle (VC_NUM=2, D=4) -> empty_o=2'b11, full_o=0, count_o=0, data_o=0.
- Write 0xA1,0xA2,0xA3,0xA4 to VC0 -> count0=4, full_o=2'b01, almost_full_o=2'b01 from the 3rd write, VC1 still empty.
- Fifth write 0xA5 to VC0 while full, no read -> overflow_o=2'b01 for exactly one cycle; count0 stays 4; 0xA5 not stored.
- VC0 full, read VC0 and write 0xB0 to VC0 in the same cycle -> both accepted, count0=4; drain order 0xA2,0xA3,0xA4,0xB0.
- FWFT (REG_OUT=0): write 0x11 to VC1, set rd_vc_i=1 -> data_o=0x11 with no rd_en_i. REG_OUT=1: same stimulus plus rd_en_i -> data_o=0x11 one cycle after the read.
- Read an empty VC1 -> underflow_o=2'b10 pulse. Fill VC0 with 3 entries, assert rst_ni low mid-burst -> all channels empty immediately, count_o=0.
